registro_n_bits_param: RTL

- Parametrised successor of the team's 4-bit universal shift register.
- WIDTH-bit register with the same four modes: serial shift, rotate, parallel load and hold, plus a serial-out bit.
- Adds a burst engine: one START command shifts or rotates CUENTA positions over successive cycles, with a BUSY/DONE handshake.
- Sits wherever a datapath needs multi-position serialisation without a controller stepping it each cycle.

---
 rtl/registro_n_bits_param_pkg.sv | 18 +
 rtl/registro_n_bits_param_if.sv | 42 ++++
 rtl/registro_burst_ctrl.sv | 84 ++++++++
 rtl/registro_n_bits_param.sv | 80 ++++++++
 4 files changed

// File: rtl/registro_n_bits_param_pkg.sv
// Shared definitions for the parametrised universal shift register:
// operating modes, shift directions and the burst FSM state encoding.
package registro_pkg;

  localparam logic [1:0] MODO_SHIFT = 2'b00;
  localparam logic [1:0] MODO_ROT   = 2'b01;
  localparam logic [1:0] MODO_LOAD  = 2'b10;
  localparam logic [1:0] MODO_HOLD  = 2'b11;

  localparam logic DIR_IZQ = 1'b0;  // toward MSB
  localparam logic DIR_DER = 1'b1;  // toward LSB

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/registro_n_bits_param_if.sv
// Bus interface of registro_n_bits_param: control/data inputs and the
// register, serial and handshake outputs.
// Optional build macro: REG_PARITY_EN adds the registered parity output.
interface registro_n_bits_param_if #(
  parameter int WIDTH    = 8,
  parameter int CUENTA_W = 4
);
  logic                enb;
  logic                s_in;
  logic                dir;
  logic [1:0]          modo;
  logic [WIDTH-1:0]    d;
  logic                start;
  logic [CUENTA_W-1:0] cuenta;
  logic [WIDTH-1:0]    q;
  logic                s_out;
  logic                busy;
  logic                done;
`ifdef REG_PARITY_EN
  logic                paridad;

  modport master (
    output enb, s_in, dir, modo, d, start, cuenta,
    input  q, s_out, busy, done, paridad
  );

  modport slave (
    input  enb, s_in, dir, modo, d, start, cuenta,
    output q, s_out, busy, done, paridad
  );
`else
  modport master (
    output enb, s_in, dir, modo, d, start, cuenta,
    input  q, s_out, busy, done
  );

  modport slave (
    input  enb, s_in, dir, modo, d, start, cuenta,
    output q, s_out, busy, done
  );
`endif
endinterface

// File: rtl/registro_burst_ctrl.sv
// Burst controller: IDLE/SHIFT FSM, position counter, latched burst
// mode/direction and the BUSY/DONE handshake. Tells the datapath which
// operation is effective and when to apply one step.
module registro_burst_ctrl
  import registro_pkg::*;
#(
  parameter int CUENTA_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb,
  input  logic                start,
  input  logic [1:0]          modo,
  input  logic                dir,
  input  logic [CUENTA_W-1:0] cuenta,
  output logic [1:0]          eff_modo,
  output logic                eff_dir,
  output logic                step,
  output logic                busy,
  output logic                done
);

  state_t              state;
  state_t              state_nxt;
  logic [CUENTA_W-1:0] cnt;
  logic                lat_rot;
  logic                lat_dir;
  logic                accept;
  logic                cnt_zero;

  // A burst is only accepted from IDLE and only for shift/rotate modes.
  assign accept   = (state == ST_IDLE) && enb && start && !modo[1];
  assign cnt_zero = (cnt == '0);

  // Next-state logic: leave SHIFT on the enabled edge that finds the count spent.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: if (enb && cnt_zero) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register, counter, latched mode/dir and one-cycle DONE pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      lat_rot <= 1'b0;
      lat_dir <= 1'b0;
      done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      if (enb) begin
        state <= state_nxt;
        if (accept) begin
          cnt     <= cuenta;
          lat_rot <= modo[0];
          lat_dir <= dir;
        end else if (state == ST_SHIFT && !cnt_zero) begin
          cnt <= cnt - CUENTA_W'(1);
        end
        if (state == ST_SHIFT && cnt_zero) done <= 1'b1;
      end
    end
  end

  // Outputs: effective mode/dir and step strobe for the datapath.
  always_comb begin
    busy     = (state == ST_SHIFT);
    eff_modo = modo;
    eff_dir  = dir;
    step     = enb && !accept;
    if (state == ST_SHIFT) begin
      eff_modo = lat_rot ? MODO_ROT : MODO_SHIFT;
      eff_dir  = lat_dir;
      step     = enb && !cnt_zero;
    end
  end

endmodule

// File: rtl/registro_n_bits_param.sv
// WIDTH-bit universal shift register (shift, rotate, load, hold) with a
// serial-out bit and a multi-position burst engine.
// Optional build macro: REG_PARITY_EN adds a registered even-parity output.
module registro_n_bits_param
  import registro_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CUENTA_W = 4
) (
  input logic                   clk,
  input logic                   rst,
  registro_n_bits_param_if.slave bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic [1:0]       eff_modo;
  logic             eff_dir;
  logic             step;
  logic             busy;
  logic             done;

  registro_burst_ctrl #(
    .CUENTA_W (CUENTA_W)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .enb      (bus.enb),
    .start    (bus.start),
    .modo     (bus.modo),
    .dir      (bus.dir),
    .cuenta   (bus.cuenta),
    .eff_modo (eff_modo),
    .eff_dir  (eff_dir),
    .step     (step),
    .busy     (busy),
    .done     (done)
  );

  // Next register value for one step of the effective operation.
  always_comb begin
    q_nxt = q;
    if (step) begin
      unique case (eff_modo)
        MODO_SHIFT: q_nxt = (eff_dir == DIR_DER) ? {bus.s_in, q[WIDTH-1:1]}
                                                 : {q[WIDTH-2:0], bus.s_in};
        MODO_ROT:   q_nxt = (eff_dir == DIR_DER) ? {q[0], q[WIDTH-1:1]}
                                                 : {q[WIDTH-2:0], q[WIDTH-1]};
        MODO_LOAD:  q_nxt = bus.d;
        default:    q_nxt = q;
      endcase
    end
  end

  // Register contents; q_nxt already equals q whenever no step is due.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= q_nxt;
  end

  // Serial out follows the bit about to leave the register in shift mode.
  always_comb begin
    bus.s_out = 1'b0;
    if (eff_modo == MODO_SHIFT)
      bus.s_out = (eff_dir == DIR_DER) ? q[0] : q[WIDTH-1];
  end

  assign bus.q    = q;
  assign bus.busy = busy;
  assign bus.done = done;

`ifdef REG_PARITY_EN
  // Parity of the value being loaded, so it always matches the current q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.paridad <= 1'b0;
    else     bus.paridad <= ^q_nxt;
  end
`endif

endmodule
